// File: rtl/ball_datapath_pkg.sv
// Shared constants, event codes and helper types for the Pong ball datapath.
// The control unit imports the same package, so the codes below are the contract between the two blocks.
package ball_datapath_pkg;

    // Screen, ball and paddle geometry in pixels
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_X_L   = 16;
    localparam int PADDLE_X_R   = 616;
    localparam int STEP         = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    // Derived positions as sized values
    localparam logic [9:0] X_MAX      = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MAX      = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] CX         = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] CY         = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] SNAP_L     = 10'(PADDLE_X_L + PADDLE_W);
    localparam logic [9:0] SNAP_R     = 10'(PADDLE_X_R - BALL_SIZE);
    localparam logic [5:0] SERVE_LOAD = 6'(SERVE_FRAMES);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [2:0] STEP_BASE  = 3'(STEP);
    localparam logic [2:0] STEP_MAX   = 3'(2 * STEP);

    // Control words from the control unit
    localparam logic [3:0] CW_PXPY     = 4'b0001;
    localparam logic [3:0] CW_MXMY     = 4'b0010;
    localparam logic [3:0] CW_PXMY     = 4'b0100;
    localparam logic [3:0] CW_MXPY     = 4'b0011;
    localparam logic [3:0] CW_RECENTRE = 4'b0101;

    // Set words returned to the control unit
    localparam logic [3:0] SW_NONE  = 4'b0000;
    localparam logic [3:0] SW_PAD_R = 4'b0001;
    localparam logic [3:0] SW_PAD_L = 4'b0010;
    localparam logic [3:0] SW_TOP   = 4'b0011;
    localparam logic [3:0] SW_BOT   = 4'b0100;
    localparam logic [3:0] SW_GOAL  = 4'b0101;

    // Direction of travel, one flag per signed axis
    typedef struct packed {
        logic px;
        logic mx;
        logic py;
        logic my;
    } dir_t;

    // goal_l: left player scores (ball at right edge); goal_r: right player scores
    typedef struct packed {
        logic goal_l;
        logic goal_r;
        logic pad_l;
        logic pad_r;
        logic top;
        logic bot;
    } hits_t;

    function automatic dir_t decode_dir(input logic [3:0] cw);
        dir_t d;
        d = '0;
        case (cw)
            CW_PXPY: begin d.px = 1'b1; d.py = 1'b1; end
            CW_MXMY: begin d.mx = 1'b1; d.my = 1'b1; end
            CW_PXMY: begin d.px = 1'b1; d.my = 1'b1; end
            CW_MXPY: begin d.mx = 1'b1; d.py = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    // One axis step, clamped to [0, lim]
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                             input logic dec, input logic [2:0] step,
                                             input logic [9:0] lim);
        logic [10:0] sum;
        logic [9:0]  res;
        sum = {1'b0, pos} + {8'd0, step};
        res = pos;
        if (inc) begin
            res = (sum > {1'b0, lim}) ? lim : sum[9:0];
        end else if (dec) begin
            res = (pos < {7'd0, step}) ? 10'd0 : pos - {7'd0, step};
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_datapath_collision.sv
// ball_collision_check: combinational border/paddle/goal detector for the ball datapath.
// A goal masks every other flag; a paddle hit may coexist with a border flag.
module ball_collision_check
    import ball_datapath_pkg::*;
(
    input  logic [9:0] ball_x_i,
    input  logic [9:0] ball_y_i,
    input  logic [3:0] dir_i,
    input  logic [9:0] paddle_y_left_i,
    input  logic [9:0] paddle_y_right_i,
    output logic [5:0] hits_o
);

    // Paddle span comparisons need an extra bit: paddle_y + PADDLE_H can exceed 1023
    localparam logic [10:0] BS_W      = 11'(BALL_SIZE);
    localparam logic [10:0] PH_W      = 11'(PADDLE_H);
    localparam logic [10:0] PL_FACE_W = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0] PL_BACK_W = 11'(PADDLE_X_L);
    localparam logic [10:0] PR_FACE_W = 11'(PADDLE_X_R);
    localparam logic [10:0] PR_BACK_W = 11'(PADDLE_X_R + PADDLE_W);

    dir_t        dir;
    hits_t       hits;
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] pyl_w;
    logic [10:0] pyr_w;

    assign dir   = dir_t'(dir_i);
    assign x_w   = {1'b0, ball_x_i};
    assign y_w   = {1'b0, ball_y_i};
    assign pyl_w = {1'b0, paddle_y_left_i};
    assign pyr_w = {1'b0, paddle_y_right_i};

    // Evaluate every hit condition for the current position and direction
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        hits        = '0;
        hits.goal_r = dir.mx && (ball_x_i == 10'd0);
        hits.goal_l = dir.px && (ball_x_i == X_MAX);
        if (!(hits.goal_l || hits.goal_r)) begin
            hits.pad_l = dir.mx && (x_w <= PL_FACE_W) && (x_w + BS_W > PL_BACK_W)
                         && (y_w + BS_W > pyl_w) && (y_w < pyl_w + PH_W);
            hits.pad_r = dir.px && (x_w + BS_W >= PR_FACE_W) && (x_w < PR_BACK_W)
                         && (y_w + BS_W > pyr_w) && (y_w < pyr_w + PH_W);
            hits.top   = dir.my && (ball_y_i == 10'd0);
            hits.bot   = dir.py && (ball_y_i == Y_MAX);
        end
    end

    assign hits_o = hits;

endmodule

// File: rtl/ball_datapath.sv
// ball_datapath: moves the Pong ball once per frame, reports border/paddle/goal events as
// one-cycle set-word pulses and keeps the scores.
// Optional feature: define BALL_SPEEDUP_EN to raise the step by one every 4th paddle hit.
module ball_datapath
    import ball_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [3:0] cw_ballMovement,
    input  logic [9:0] paddle_y_left,
    input  logic [9:0] paddle_y_right,
    output logic [3:0] sw_ballMovement,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over
);

    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic [5:0] serve_cnt_q, serve_cnt_d;
    dir_t       dir_q, dir_d;
    logic       chk_q, chk_d;        // high in the cycle after a move: detection window
    logic [3:0] sw_q, sw_d;
    logic [3:0] pend_q, pend_d;      // border event deferred behind a paddle hit
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       game_over_q, game_over_d;
    logic [2:0] step;
    dir_t       cw_dir;
    logic [5:0] hits_raw;
    hits_t      hits;

`ifdef BALL_SPEEDUP_EN
    logic [2:0] step_q, step_d;
    logic [1:0] hit_cnt_q, hit_cnt_d;
    assign step = step_q;
`else
    assign step = STEP_BASE;
`endif

    assign cw_dir = decode_dir(cw_ballMovement);
    assign hits   = hits_t'(hits_raw);

    ball_collision_check u_collision (
        .ball_x_i         (ball_x_q),
        .ball_y_i         (ball_y_q),
        .dir_i            (dir_q),
        .paddle_y_left_i  (paddle_y_left),
        .paddle_y_right_i (paddle_y_right),
        .hits_o           (hits_raw)
    );

    // Next-state: recentre beats everything, then event resolution, then frame moves
    always_comb begin
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        serve_cnt_d = serve_cnt_q;
        dir_d       = dir_q;
        chk_d       = 1'b0;
        sw_d        = pend_q;
        pend_d      = SW_NONE;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        game_over_d = game_over_q;
`ifdef BALL_SPEEDUP_EN
        step_d      = step_q;
        hit_cnt_d   = hit_cnt_q;
`endif
        if (cw_ballMovement == CW_RECENTRE) begin
            ball_x_d    = CX;
            ball_y_d    = CY;
            serve_cnt_d = SERVE_LOAD;
            sw_d        = SW_NONE;
        end else if (chk_q) begin
            if (hits.goal_l || hits.goal_r) begin
                sw_d = SW_GOAL;
                if (hits.goal_l && score_l_q != WIN) score_l_d = score_l_q + 4'd1;
                if (hits.goal_r && score_r_q != WIN) score_r_d = score_r_q + 4'd1;
                if (score_l_d == WIN || score_r_d == WIN) begin
                    game_over_d = 1'b1;
                    ball_x_d    = CX;
                    ball_y_d    = CY;
                end
`ifdef BALL_SPEEDUP_EN
                step_d    = STEP_BASE;
                hit_cnt_d = 2'd0;
`endif
            end else if (hits.pad_l || hits.pad_r) begin
                sw_d     = hits.pad_l ? SW_PAD_L : SW_PAD_R;
                ball_x_d = hits.pad_l ? SNAP_L : SNAP_R;
                pend_d   = hits.top ? SW_TOP : (hits.bot ? SW_BOT : SW_NONE);
`ifdef BALL_SPEEDUP_EN
                hit_cnt_d = hit_cnt_q + 2'd1;
                if (hit_cnt_q == 2'd3 && step_q != STEP_MAX) step_d = step_q + 3'd1;
`endif
            end else if (hits.top) begin
                sw_d = SW_TOP;
            end else if (hits.bot) begin
                sw_d = SW_BOT;
            end else begin
                sw_d = SW_NONE;
            end
        end else if (frame_tick && !game_over_q) begin
            if (serve_cnt_q != 6'd0) begin
                serve_cnt_d = serve_cnt_q - 6'd1;
            end else begin
                ball_x_d = step_axis(ball_x_q, cw_dir.px, cw_dir.mx, step, X_MAX);
                ball_y_d = step_axis(ball_y_q, cw_dir.py, cw_dir.my, step, Y_MAX);
                dir_d    = cw_dir;
                chk_d    = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            ball_x_q    <= CX;
            ball_y_q    <= CY;
            serve_cnt_q <= SERVE_LOAD;
            dir_q       <= '0;
            chk_q       <= 1'b0;
            sw_q        <= SW_NONE;
            pend_q      <= SW_NONE;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            game_over_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            step_q      <= STEP_BASE;
            hit_cnt_q   <= 2'd0;
`endif
        end else begin
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            serve_cnt_q <= serve_cnt_d;
            dir_q       <= dir_d;
            chk_q       <= chk_d;
            sw_q        <= sw_d;
            pend_q      <= pend_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            game_over_q <= game_over_d;
`ifdef BALL_SPEEDUP_EN
            step_q      <= step_d;
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    assign sw_ballMovement = sw_q;
    assign ball_x          = ball_x_q;
    assign ball_y          = ball_y_q;
    assign score_left      = score_l_q;
    assign score_right     = score_r_q;
    assign game_over       = game_over_q;

endmodule

// File: tb/tb_ball_datapath.sv
// Directed testbench for ball_datapath: serve hold, borders, paddle hits and snaps,
// paddle+border ordering, goals, scoring to game over, and reset.
module tb_ball_datapath;

    localparam logic [3:0] C_PXPY = 4'b0001;
    localparam logic [3:0] C_MXMY = 4'b0010;
    localparam logic [3:0] C_PXMY = 4'b0100;
    localparam logic [3:0] C_MXPY = 4'b0011;
    localparam logic [3:0] C_RCTR = 4'b0101;
    localparam logic [9:0] FAR    = 10'd1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic [3:0] cw_ballMovement;
    logic [9:0] paddle_y_left;
    logic [9:0] paddle_y_right;
    logic [3:0] sw_ballMovement;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // Samples captured around each tick (T = tick cycle)
    logic [9:0] x_t1, y_t1, x_t2, y_t2;
    logic [3:0] sw_t1, sw_t2, sw_t3, sr_t2;

    always #5 clk = ~clk;

    ball_datapath dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_tick      (frame_tick),
        .cw_ballMovement (cw_ballMovement),
        .paddle_y_left   (paddle_y_left),
        .paddle_y_right  (paddle_y_right),
        .sw_ballMovement (sw_ballMovement),
        .ball_x          (ball_x),
        .ball_y          (ball_y),
        .score_left      (score_left),
        .score_right     (score_right),
        .game_over       (game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick with 4-cycle spacing; samples T+1, T+2, T+3
    task automatic tick(input logic [3:0] cw);
        @(posedge clk); #1;
        cw_ballMovement = cw;
        frame_tick      = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        x_t1  = ball_x;
        y_t1  = ball_y;
        sw_t1 = sw_ballMovement;
        @(posedge clk); #1;
        x_t2  = ball_x;
        y_t2  = ball_y;
        sw_t2 = sw_ballMovement;
        sr_t2 = score_right;
        @(posedge clk); #1;
        sw_t3 = sw_ballMovement;
    endtask

    task automatic ticks(input logic [3:0] cw, input int n);
        for (int i = 0; i < n; i++) tick(cw);
    endtask

    task automatic recentre();
        @(posedge clk); #1;
        cw_ballMovement = C_RCTR;
        @(posedge clk); #1;
        cw_ballMovement = 4'b0000;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        frame_tick      = 1'b0;
        cw_ballMovement = 4'b0000;
        paddle_y_left   = FAR;
        paddle_y_right  = FAR;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("rst_x", ball_x, 316);
        check("rst_y", ball_y, 236);
        check("rst_sw", sw_ballMovement, 0);
        check("rst_score_l", score_left, 0);
        check("rst_score_r", score_right, 0);
        check("rst_game_over", game_over, 0);

        // Reset mid-serve reloads the serve counter
        ticks(C_MXMY, 20);
        check("serve_hold_x", ball_x, 316);
        pulse_reset();
        ticks(C_MXMY, 60);
        check("serve60_x", ball_x, 316);
        check("serve60_y", ball_y, 236);
        tick(C_MXMY);
        check("tick61_x", x_t1, 314);
        check("tick61_y", y_t1, 234);
        check("tick61_sw", sw_t2, 0);

        // Travel to the top border, then slide along it
        ticks(C_MXMY, 117);
        check("nav_a_x", ball_x, 80);
        check("nav_a_y", ball_y, 0);
        ticks(C_MXMY, 29);
        check("nav_b_x", ball_x, 22);
        tick(C_MXPY);
        check("nav_c_x", x_t1, 20);
        check("nav_c_y", y_t1, 2);

        // Top border event from (20,2)
        tick(C_MXMY);
        check("top_x", x_t1, 18);
        check("top_y", y_t1, 0);
        check("top_sw_t1", sw_t1, 0);
        check("top_sw_t2", sw_t2, 3);
        check("top_sw_t3", sw_t3, 0);

        // Left paddle hit from (26,100)
        ticks(C_PXPY, 27);
        check("nav_d_x", ball_x, 72);
        check("nav_d_y", ball_y, 54);
        ticks(C_MXPY, 23);
        check("nav_e_x", ball_x, 26);
        check("nav_e_y", ball_y, 100);
        paddle_y_left = 10'd80;
        tick(C_MXMY);
        check("padl_x_t1", x_t1, 24);
        check("padl_y_t1", y_t1, 98);
        check("padl_sw_t2", sw_t2, 2);
        check("padl_x_t2", x_t2, 24);
        check("padl_sw_t3", sw_t3, 0);

        // Hit inside the paddle face snaps x back out
        tick(C_MXMY);
        check("snap_x_t1", x_t1, 22);
        check("snap_sw_t2", sw_t2, 2);
        check("snap_x_t2", x_t2, 24);

        // Paddle hit plus top border from (26,2)
        paddle_y_left = FAR;
        ticks(C_PXMY, 24);
        check("nav_f_x", ball_x, 72);
        check("nav_f_y", ball_y, 48);
        ticks(C_MXMY, 23);
        check("nav_g_x", ball_x, 26);
        check("nav_g_y", ball_y, 2);
        paddle_y_left = 10'd0;
        tick(C_MXMY);
        check("padtop_sw_t2", sw_t2, 2);
        check("padtop_sw_t3", sw_t3, 3);
        check("padtop_x_t2", x_t2, 24);
        check("padtop_y_t2", y_t2, 0);

        // Goal for the right player from (2,300)
        paddle_y_left = FAR;
        tick(C_MXMY);
        check("nav_h_x", x_t1, 22);
        check("nav_h_y", y_t1, 0);
        ticks(C_PXPY, 70);
        check("nav_i_x", ball_x, 162);
        check("nav_i_y", ball_y, 140);
        ticks(C_MXPY, 80);
        check("nav_j_x", ball_x, 2);
        check("nav_j_y", ball_y, 300);
        paddle_y_left = 10'd0;
        tick(C_MXPY);
        check("goal1_x_t1", x_t1, 0);
        check("goal1_sw_t2", sw_t2, 5);
        check("goal1_score_t2", sr_t2, 1);
        check("goal1_sw_t3", sw_t3, 0);
        check("goal1_x_t2", x_t2, 0);
        recentre();
        check("recentre_x", ball_x, 316);
        check("recentre_y", ball_y, 236);
        tick(C_MXMY);
        check("recentre_serve_x", x_t1, 316);

        // Eight more goals; each lands in the bottom corner so the border is dropped
        paddle_y_left = FAR;
        for (int g = 0; g < 8; g++) begin
            recentre();
            ticks(C_MXPY, 60 + 157);
            tick(C_MXPY);
            check($sformatf("goal%0d_pos_x", g + 2), x_t1, 0);
            check($sformatf("goal%0d_pos_y", g + 2), y_t1, 472);
            check($sformatf("goal%0d_sw_t2", g + 2), sw_t2, 5);
            check($sformatf("goal%0d_sw_t3", g + 2), sw_t3, 0);
            check($sformatf("goal%0d_score", g + 2), sr_t2, g + 2);
        end
        check("final_score_r", score_right, 9);
        check("final_score_l", score_left, 0);
        check("game_over_set", game_over, 1);
        check("go_centre_x", x_t2, 316);
        check("go_centre_y", y_t2, 236);
        ticks(C_MXPY, 5);
        check("frozen_x", x_t1, 316);
        check("frozen_y", y_t1, 236);
        check("frozen_sw_t2", sw_t2, 0);
        check("frozen_sw_t3", sw_t3, 0);
        check("frozen_score_r", score_right, 9);

        // Only reset clears game over
        pulse_reset();
        check("rst2_game_over", game_over, 0);
        check("rst2_score_r", score_right, 0);
        check("rst2_sw", sw_ballMovement, 0);

        // Right paddle hits with bottom border; step after 4 hits
        paddle_y_right = 10'd440;
        ticks(C_PXPY, 60 + 145);
        check("nav_k_x", ball_x, 606);
        check("nav_k_y", ball_y, 472);
        for (int h = 0; h < 4; h++) begin
            tick(C_PXPY);
            check($sformatf("padr%0d_x_t1", h), x_t1, (h == 0) ? 608 : 610);
            check($sformatf("padr%0d_sw_t2", h), sw_t2, 1);
            check($sformatf("padr%0d_sw_t3", h), sw_t3, 4);
            check($sformatf("padr%0d_x_t2", h), x_t2, 608);
        end
        tick(C_MXMY);
`ifdef BALL_SPEEDUP_EN
        check("speed_x", x_t1, 605);
        check("speed_y", y_t1, 469);
`else
        check("speed_x", x_t1, 606);
        check("speed_y", y_t1, 470);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
